// File: rtl/minv_loader_if.sv
// Host-side operand stream and result stream of the modular-inverse loader.
// The loader connects through the slave modport, the host/consumer through master.
interface minv_loader_if;
    logic [15:0] host_din;
    logic        host_valid;
    logic        host_ready;
    logic [15:0] res_dout;
    logic        res_valid;
    logic        res_ready;
    logic        res_last;
    logic        res_err;

    modport slave (
        input  host_din, host_valid, res_ready,
        output host_ready, res_dout, res_valid, res_last, res_err
    );

    modport master (
        output host_din, host_valid, res_ready,
        input  host_ready, res_dout, res_valid, res_last, res_err
    );
endinterface

// File: rtl/minv_loader.sv
// Streams operand a and modulus p word-serially into the inverse datapath, starts it,
// waits for the result (with timeout) and streams the 256-bit result back out.
//
// state    | meaning
// IDLE     | waiting for word 0 of operand a
// LOAD_A   | accepting words 1..NW-1 of a, pulsing regu_we
// LOAD_P   | accepting words 0..NW-1 of p, pulsing regv_we/regp_we
// START    | issuing the one-cycle minv_en pulse
// WAIT     | waiting for minv_rdy or timeout
// UNLOAD   | presenting result words LSW first
module minv_loader #(
    parameter int NW     = 16,
    parameter int TO_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    minv_loader_if.slave       bus,
    output logic [15:0]        datain,
    output logic               regu_we,
    output logic               regv_we,
    output logic               regp_we,
    output logic               minv_en,
    input  logic               minv_rdy,
    input  logic               minv_flag,
    input  logic [NW*16-1:0]   result_in,
    output logic               busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_P, S_START, S_WAIT, S_UNLOAD
    } state_t;

    localparam logic [3:0]  W_LAST = 4'(NW - 1);
    localparam logic [16:0] T_LAST = 17'(TO_CYC - 1);

    state_t             state, state_nx;
    logic [3:0]         wcnt, wcnt_nx;
    logic [16:0]        tcnt;
    logic [NW*16-1:0]   res_buf;
    logic               res_err_q;
    logic               host_acc;
    logic               res_acc;
    logic               timeout;

    // host_ready held low while reset is asserted, not just after the first edge
    assign bus.host_ready = ~rst & ((state == S_IDLE) | (state == S_LOAD_A) | (state == S_LOAD_P));
    assign host_acc       = bus.host_valid & bus.host_ready;
    assign bus.res_valid  = (state == S_UNLOAD);
    assign res_acc        = bus.res_valid & bus.res_ready;
    assign bus.res_dout   = res_buf[15:0];
    assign bus.res_last   = bus.res_valid & (wcnt == W_LAST);
    assign bus.res_err    = res_err_q;
    assign busy           = (state != S_IDLE);
    assign timeout        = (state == S_WAIT) & ~minv_rdy & (tcnt == T_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            wcnt  <= 4'd0;
        end else begin
            state <= state_nx;
            wcnt  <= wcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        wcnt_nx  = wcnt;
        case (state)
            S_IDLE: begin
                if (host_acc) begin
                    state_nx = S_LOAD_A;
                    wcnt_nx  = 4'd1;
                end
            end
            S_LOAD_A: begin
                if (host_acc) begin
                    if (wcnt == W_LAST) begin
                        state_nx = S_LOAD_P;
                        wcnt_nx  = 4'd0;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end
            end
            S_LOAD_P: begin
                if (host_acc) begin
                    if (wcnt == W_LAST) begin
                        state_nx = S_START;
                        wcnt_nx  = 4'd0;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end
            end
            S_START: begin
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (minv_rdy || timeout) begin
                    state_nx = S_UNLOAD;
                    wcnt_nx  = 4'd0;
                end
            end
            S_UNLOAD: begin
                if (res_acc) begin
                    if (wcnt == W_LAST) begin
                        state_nx = S_IDLE;
                        wcnt_nx  = 4'd0;
                    end else begin
                        wcnt_nx = wcnt + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = S_IDLE;
                wcnt_nx  = 4'd0;
            end
        endcase
    end

    // Enables are registered so each pulse lines up with the registered datain word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            datain    <= 16'd0;
            regu_we   <= 1'b0;
            regv_we   <= 1'b0;
            regp_we   <= 1'b0;
            minv_en   <= 1'b0;
            tcnt      <= 17'd0;
            res_buf   <= '0;
            res_err_q <= 1'b0;
        end else begin
            regu_we <= host_acc & ((state == S_IDLE) | (state == S_LOAD_A));
            regv_we <= host_acc & (state == S_LOAD_P);
            regp_we <= host_acc & (state == S_LOAD_P);
            minv_en <= (state == S_START);
            if (host_acc) begin
                datain <= bus.host_din;
            end
            if (host_acc && (state == S_IDLE)) begin
                res_err_q <= 1'b0;
            end
            case (state)
                S_START: tcnt <= 17'd0;
                S_WAIT: begin
                    tcnt <= tcnt + 17'd1;
                    if (minv_rdy) begin
                        res_buf   <= result_in;
                        res_err_q <= minv_flag;
                    end else if (timeout) begin
                        res_buf   <= '0;
                        res_err_q <= 1'b1;
                    end
                end
                S_UNLOAD: begin
                    if (res_acc) begin
                        res_buf <= res_buf >> 16;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
